// File: rtl/hero_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hero_arb_pkg
//  Brief    : Arbiter state encoding and default sizing for hero_write_arb.
//  Revision : 1.0  initial release
// ============================================================================
package hero_arb_pkg;
   import hero_bus_pkg::*;

   localparam int HERO_ARB_NUM_REQ   = 4;
   localparam int HERO_ARB_MAX_BEATS = 16;

   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_LOCK = 1'b1
   } ARB_STATE_E;

endpackage : hero_arb_pkg
`default_nettype wire

// File: rtl/hero_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hero_bus_pkg
//  Brief    : Hero write bus beat type and cycle-type encoding.
//  Revision : 1.0  initial release
// ============================================================================
package hero_bus_pkg;

   // Beat qualifier; anything other than IDLE is an offered beat.
   typedef enum logic [1:0] {
      CYCLE_TYPE_IDLE  = 2'd0,
      CYCLE_TYPE_VALID = 2'd1,
      CYCLE_TYPE_DONE  = 2'd2
   } CYCLE_TYPE_E;

   // 46-bit hero write beat: qualifier, address, write data.
   typedef struct packed {
      CYCLE_TYPE_E cycle_type;
      logic [11:0] addr;
      logic [31:0] wdat;
   } hero_write_t;

endpackage : hero_bus_pkg
`default_nettype wire

// File: rtl/hero_write_arb_if.sv
`default_nettype none
// ============================================================================
//  Module   : hero_write_arb_if
//  Brief    : Requester-side and consumer-side signals of the hero arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface hero_write_arb_if
   import hero_bus_pkg::*;
   import hero_arb_pkg::*;
#(
   parameter int NUM_REQ = HERO_ARB_NUM_REQ
);
   localparam int IDW = $clog2(NUM_REQ);

   hero_write_t        req_bus [NUM_REQ];
   logic [NUM_REQ-1:0] req_rdy;
   hero_write_t        hero_out;
   logic               hero_out_rdy;
   logic               grant_vld;
   logic [IDW-1:0]     grant_id;
   logic               err_overrun;

   // Arbiter view
   modport slave (
      input  req_bus, hero_out_rdy,
      output req_rdy, hero_out, grant_vld, grant_id, err_overrun
   );

   // Environment view (requesters + consumer)
   modport master (
      output req_bus, hero_out_rdy,
      input  req_rdy, hero_out, grant_vld, grant_id, err_overrun
   );

endinterface : hero_write_arb_if
`default_nettype wire

// File: rtl/hero_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : hero_rr_pick
//  Brief    : Combinational round-robin picker: first request at/after ptr.
//  Revision : 1.0  initial release
// ============================================================================
module hero_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  wire logic [NUM_REQ-1:0] req,
   input  wire logic [IDW-1:0]     ptr,
   output logic      [NUM_REQ-1:0] onehot,
   output logic      [IDW-1:0]     idx,
   output logic                    any
);

   // Scan from the farthest offset back to ptr so the nearest hit wins.
   always_comb begin
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % NUM_REQ]) begin
            onehot = '0;
            onehot[(int'(ptr) + k) % NUM_REQ] = 1'b1;
            idx    = IDW'((int'(ptr) + k) % NUM_REQ);
            any    = 1'b1;
         end
      end
   end

endmodule : hero_rr_pick
`default_nettype wire

// File: rtl/hero_write_arb.sv
`default_nettype none
// ============================================================================
//  Module   : hero_write_arb
//  Brief    : Transaction-locked round-robin arbiter for the hero write bus,
//             registered output stage with backpressure, overrun policing.
//  Revision : 1.0  initial release
// ============================================================================
module hero_write_arb
   import hero_bus_pkg::*;
   import hero_arb_pkg::*;
#(
   parameter int NUM_REQ   = HERO_ARB_NUM_REQ,
   parameter int MAX_BEATS = HERO_ARB_MAX_BEATS
) (
   input wire logic         clk,
   input wire logic         rst_n,
   hero_write_arb_if.slave  bus
);
   localparam int IDW = $clog2(NUM_REQ);
   localparam int CW  = $clog2(MAX_BEATS + 1);

   ARB_STATE_E         state_q, state_d;
   logic [IDW-1:0]     ptr_q, ptr_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   hero_write_t        hero_out_q, hero_out_d;
   logic               grant_vld_q, grant_vld_d;
   logic [IDW-1:0]     grant_id_q, grant_id_d;
   logic               err_q, err_d;

   logic [NUM_REQ-1:0] req_vec;
   logic [NUM_REQ-1:0] pick_onehot;
   logic [IDW-1:0]     pick_idx;
   logic               pick_any;
   logic [NUM_REQ-1:0] req_rdy_cmb;
   hero_write_t        owner_beat;
   logic               out_xfer;
   logic               load_ok;

   function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
      return (v == IDW'(NUM_REQ - 1)) ? '0 : v + 1'b1;
   endfunction

   generate
      for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
         assign req_vec[i] = (bus.req_bus[i].cycle_type != CYCLE_TYPE_IDLE);
      end
   endgenerate

   hero_rr_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick (
      .req    (req_vec),
      .ptr    (ptr_q),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   assign out_xfer = (hero_out_q.cycle_type != CYCLE_TYPE_IDLE) && bus.hero_out_rdy;
   assign load_ok  = (hero_out_q.cycle_type == CYCLE_TYPE_IDLE) || out_xfer;

   // Arbitration, lock tracking, output-stage load and overrun truncation.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      grant_vld_d = grant_vld_q;
      grant_id_d  = grant_id_q;
      err_d       = 1'b0;
      hero_out_d  = out_xfer ? '0 : hero_out_q;
      req_rdy_cmb = '0;
      owner_beat  = bus.req_bus[grant_id_q];
      case (state_q)
         ARB_IDLE: begin
            if (load_ok && pick_any) begin
               req_rdy_cmb = pick_onehot;
               hero_out_d  = bus.req_bus[pick_idx];
               if (bus.req_bus[pick_idx].cycle_type == CYCLE_TYPE_DONE) begin
                  ptr_d = wrap_inc(pick_idx);
               end else begin
                  state_d     = ARB_LOCK;
                  grant_id_d  = pick_idx;
                  grant_vld_d = 1'b1;
                  cnt_d       = CW'(1);
               end
            end
         end
         ARB_LOCK: begin
            if (load_ok && owner_beat.cycle_type != CYCLE_TYPE_IDLE) begin
               req_rdy_cmb[grant_id_q] = 1'b1;
               hero_out_d = owner_beat;
               cnt_d      = cnt_q + CW'(1);
               // A VALID at the last allowed slot is truncated into a DONE.
               if (owner_beat.cycle_type != CYCLE_TYPE_DONE &&
                   cnt_q == CW'(MAX_BEATS - 1)) begin
                  hero_out_d.cycle_type = CYCLE_TYPE_DONE;
                  err_d = 1'b1;
               end
               if (owner_beat.cycle_type == CYCLE_TYPE_DONE ||
                   cnt_q == CW'(MAX_BEATS - 1)) begin
                  state_d     = ARB_IDLE;
                  ptr_d       = wrap_inc(grant_id_q);
                  grant_vld_d = 1'b0;
                  cnt_d       = '0;
               end
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // State and output-stage registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ARB_IDLE;
         ptr_q       <= '0;
         cnt_q       <= '0;
         hero_out_q  <= '0;
         grant_vld_q <= 1'b0;
         grant_id_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         hero_out_q  <= hero_out_d;
         grant_vld_q <= grant_vld_d;
         grant_id_q  <= grant_id_d;
         err_q       <= err_d;
      end
   end

   // No beat is acknowledged while reset is held.
   assign bus.req_rdy     = rst_n ? req_rdy_cmb : '0;
   assign bus.hero_out    = hero_out_q;
   assign bus.grant_vld   = grant_vld_q;
   assign bus.grant_id    = grant_id_q;
   assign bus.err_overrun = err_q;

endmodule : hero_write_arb
`default_nettype wire
